miriscv_int_ctrl: RTL and testbench

- Interrupt controller that is the responder side of the core's interrupt interface.
- Collects level-sensitive requests from peripherals and filters them with the mie mask from the CSR file.
- Presents one interrupt at a time to the core as a request plus mcause.
- Completes the handshake when the core signals mret: it pulses a one-hot completion back to the served peripheral, then resumes round-robin scanning from the next line.
- Sits between the peripheral bank and the core inside miriscv_top.

---
 rtl/miriscv_int_ctrl.sv | 122 ++++++++++++
 tb/tb_miriscv_int_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/miriscv_int_ctrl.sv
// ---------------------------------------------------------------------------
// miriscv_int_ctrl
//
// Responder side of the core's interrupt interface. Level-sensitive requests
// from the peripheral bank are masked with mie and examined one line per
// cycle in round-robin order. The first enabled, requesting line found is
// presented to the core as irq_o plus mcause_o. When the core executes mret,
// a one-cycle one-hot completion pulse goes back to the served peripheral and
// scanning resumes from the line after it.
//
// Ports:
//   clk_i      system clock, all state updates on the rising edge
//   rst_i      synchronous reset, active-high
//   int_req_i  [N_LINES-1:0] level requests, held until the matching int_fin_o
//   mie_i      [N_LINES-1:0] per-line enable mask from the CSR file
//   irq_ret_i  one-cycle pulse from the core on mret
//   irq_o      interrupt request to the core (registered)
//   mcause_o   [31:0] {1'b1, zeros, served line index} (registered)
//   int_fin_o  [N_LINES-1:0] one-hot completion pulse (registered)
// ---------------------------------------------------------------------------
module miriscv_int_ctrl #(
   parameter int N_LINES = 32,
   parameter int IDX_W   = $clog2(N_LINES)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [N_LINES-1:0] int_req_i,
   input  logic [N_LINES-1:0] mie_i,
   input  logic               irq_ret_i,
   output logic               irq_o,
   output logic [31:0]        mcause_o,
   output logic [N_LINES-1:0] int_fin_o
);

   typedef enum logic [1:0] {
      SCAN  = 2'd0,
      SERVE = 2'd1,
      FIN   = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   idx_next;
   logic               irq_d;
   logic [31:0]        mcause_d;
   logic [N_LINES-1:0] fin_d;
   logic               hit;

   // Only the currently indexed line is looked at, so a request is detected
   // within N_LINES cycles and a hit at the current index within one.
   assign hit = int_req_i[idx_q] & mie_i[idx_q];

   // Wrap explicitly so non-power-of-two N_LINES never indexes a missing line.
   assign idx_next = (idx_q == IDX_W'(N_LINES - 1)) ? '0 : idx_q + IDX_W'(1);

   // NOTE: every output of this block gets a default before the case
   // statement, so no path through it can leave a signal unassigned and
   // infer a latch.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      irq_d    = irq_o;
      mcause_d = mcause_o;
      fin_d    = '0;

      case (state_q)
         SCAN: begin
            if (hit) begin
               state_d            = SERVE;
               irq_d              = 1'b1;
               mcause_d           = '0;
               mcause_d[31]       = 1'b1;
               mcause_d[IDX_W-1:0] = idx_q;
            end else begin
               idx_d = idx_next;
            end
         end

         // Requests and mask are ignored here: a line dropped mid-service is
         // still completed with a fin pulse once the core returns.
         SERVE: begin
            if (irq_ret_i) begin
               state_d      = FIN;
               irq_d        = 1'b0;
               fin_d[idx_q] = 1'b1;
            end
         end

         // Advancing past the served line gives round-robin fairness: a line
         // that keeps requesting waits for every other line to be examined.
         FIN: begin
            state_d = SCAN;
            idx_d   = idx_next;
         end

         default: begin
            state_d = SCAN;
            idx_d   = '0;
            irq_d   = 1'b0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this edge, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= SCAN;
         idx_q     <= '0;
         irq_o     <= 1'b0;
         mcause_o  <= '0;
         int_fin_o <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         irq_o     <= irq_d;
         mcause_o  <= mcause_d;
         int_fin_o <= fin_d;
      end
   end

endmodule

// File: tb/tb_miriscv_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_miriscv_int_ctrl
//
// Directed bench for miriscv_int_ctrl with N_LINES = 32. Inputs are driven
// 1 time unit after the rising edge and outputs are sampled at that same
// point, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_miriscv_int_ctrl;

   localparam int N_LINES = 32;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic [N_LINES-1:0] int_req_i;
   logic [N_LINES-1:0] mie_i;
   logic               irq_ret_i;
   logic               irq_o;
   logic [31:0]        mcause_o;
   logic [N_LINES-1:0] int_fin_o;

   int checks = 0;
   int errors = 0;

   miriscv_int_ctrl #(.N_LINES(N_LINES)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .int_req_i (int_req_i),
      .mie_i     (mie_i),
      .irq_ret_i (irq_ret_i),
      .irq_o     (irq_o),
      .mcause_o  (mcause_o),
      .int_fin_o (int_fin_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; invariants are checked after every edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
      check("fin_onehot0", 32'($onehot0(int_fin_o)), 32'd1);
      check("fin_while_irq", 32'((int_fin_o != '0) && irq_o), 32'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      tick();
      rst_i = 1'b0;
   endtask

   // Bounded wait for irq_o; a timeout shows up as a failed check.
   task automatic wait_irq(input int bound, input string tag);
      int n = 0;
      while (!irq_o && n < bound) begin
         tick();
         n++;
      end
      check({tag, "_irq_seen"}, 32'(irq_o), 32'd1);
   endtask

   // Waits two cycles in SERVE, pulses mret, checks the completion pulse.
   task automatic serve_and_ret(input string tag, input logic [31:0] cause,
                                input logic [N_LINES-1:0] fin);
      check({tag, "_mcause"}, mcause_o, cause);
      tick();
      tick();
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      check({tag, "_irq_low"}, 32'(irq_o), 32'd0);
      check({tag, "_fin"}, 32'(int_fin_o), 32'(fin));
      tick();
      check({tag, "_fin_clear"}, 32'(int_fin_o), 32'd0);
   endtask

   initial begin
      bit seen;
      rst_i     = 1'b1;
      int_req_i = '0;
      mie_i     = '0;
      irq_ret_i = 1'b0;
      #1;

      // Reset state.
      do_reset();
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_mcause", mcause_o, 32'h0);
      check("rst_fin", 32'(int_fin_o), 32'd0);
      check("rst_idx", 32'(dut.idx_q), 32'd0);

      // Line 5: index reaches 5 after 5 edges, irq after the 6th.
      int_req_i = 32'h1 << 5;
      mie_i     = '1;
      repeat (5) tick();
      check("t1_idx5", 32'(dut.idx_q), 32'd5);
      check("t1_irq_not_yet", 32'(irq_o), 32'd0);
      tick();
      check("t1_irq", 32'(irq_o), 32'd1);
      check("t1_mcause", mcause_o, 32'h8000_0005);
      repeat (3) tick();
      check("t1_irq_hold", 32'(irq_o), 32'd1);
      check("t1_mcause_hold", mcause_o, 32'h8000_0005);

      // mret: one-cycle fin pulse for line 5, then no further irq.
      irq_ret_i = 1'b1;
      tick();
      irq_ret_i = 1'b0;
      check("t2_irq_low", 32'(irq_o), 32'd0);
      check("t2_fin", 32'(int_fin_o), 32'h0000_0020);
      int_req_i = '0;
      tick();
      check("t2_fin_clear", 32'(int_fin_o), 32'd0);
      check("t2_mcause_kept", mcause_o, 32'h8000_0005);
      seen = 1'b0;
      repeat (64) begin
         tick();
         if (irq_o) seen = 1'b1;
      end
      check("t2_no_irq_64", 32'(seen), 32'd0);

      // Lines 3 and 7 held: round-robin order 3, 7, 3, 7.
      do_reset();
      int_req_i = (32'h1 << 3) | (32'h1 << 7);
      mie_i     = '1;
      wait_irq(40, "t3_a");
      serve_and_ret("t3_a", 32'h8000_0003, 32'h1 << 3);
      wait_irq(40, "t3_b");
      serve_and_ret("t3_b", 32'h8000_0007, 32'h1 << 7);
      wait_irq(40, "t3_c");
      serve_and_ret("t3_c", 32'h8000_0003, 32'h1 << 3);
      wait_irq(40, "t3_d");
      serve_and_ret("t3_d", 32'h8000_0007, 32'h1 << 7);

      // Masked line 9 is never served until enabled.
      do_reset();
      int_req_i = 32'h1 << 9;
      mie_i     = '0;
      seen = 1'b0;
      repeat (100) begin
         tick();
         if (irq_o) seen = 1'b1;
      end
      check("t4_masked_no_irq", 32'(seen), 32'd0);
      mie_i = 32'h1 << 9;
      wait_irq(32, "t4");
      serve_and_ret("t4", 32'h8000_0009, 32'h1 << 9);
      int_req_i = '0;

      // Line 2: dropping request and mask during service changes nothing.
      do_reset();
      int_req_i = 32'h1 << 2;
      mie_i     = '1;
      wait_irq(40, "t5");
      int_req_i = '0;
      mie_i     = ~(32'h1 << 2);
      repeat (3) tick();
      check("t5_irq_kept", 32'(irq_o), 32'd1);
      serve_and_ret("t5", 32'h8000_0002, 32'h1 << 2);

      // Reset during service of line 4 aborts without a fin pulse.
      do_reset();
      int_req_i = 32'h1 << 4;
      mie_i     = '1;
      wait_irq(40, "t6");
      check("t6_mcause", mcause_o, 32'h8000_0004);
      rst_i = 1'b1;
      tick();
      rst_i     = 1'b0;
      int_req_i = '0;
      check("t6_rst_irq", 32'(irq_o), 32'd0);
      check("t6_rst_mcause", mcause_o, 32'h0);
      check("t6_rst_fin", 32'(int_fin_o), 32'd0);
      check("t6_rst_idx", 32'(dut.idx_q), 32'd0);
      // mret pulses while scanning must not produce a completion.
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         irq_ret_i = (i % 5 == 0);
         tick();
         if (int_fin_o != '0 || irq_o) seen = 1'b1;
      end
      irq_ret_i = 1'b0;
      check("t6_no_fin_in_scan", 32'(seen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
